// File: rtl/inst_mem_loader_if.sv
// Byte-stream handshake feeding the instruction memory loader.
// The upstream source drives valid/byte; the loader drives ready.
interface inst_mem_loader_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (output in_valid, output in_byte, input in_ready);
    modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/inst_mem_loader.sv
// Boot loader: takes a length-prefixed byte stream, packs big-endian 32-bit words
// and writes them to instruction memory from BASE_ADDR while holding the CPU.
module inst_mem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LEN_WIDTH   = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    inst_mem_loader_if.slave     in_if,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic                 cpu_hold_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [LEN_WIDTH-1:0] words_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_FINISH
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           len_hi_q, len_hi_d;
    logic [15:0]          len_q, len_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [23:0]          word_q, word_d;
    logic [LEN_WIDTH-1:0] words_q, words_d;
    logic                 err_q, err_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 rdy;
    logic                 xfer;
    logic [15:0]          len_rx;

    assign xfer   = in_if.in_valid & rdy;
    assign len_rx = {len_hi_q, in_if.in_byte};

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            words_q    <= '0;
            err_q      <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            words_q    <= words_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
        len_hi_q <= len_hi_d;
        len_q    <= len_d;
        word_q   <= word_d;
    end

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        words_d    = words_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LEN_HI;
                    err_d   = 1'b0;
                    words_d = '0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_if.in_byte;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d      = len_rx;
                    byte_cnt_d = 2'd0;
                    if (len_rx == 16'd0) begin
                        state_d = S_FINISH;
                    end else if (32'(len_rx) > DEPTH_WORDS) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    word_d     = {word_q[15:0], in_if.in_byte};
                    // Fourth byte completes the word; latch address and data for the write cycle.
                    if (byte_cnt_q == 2'd3) begin
                        wdata_d = {word_q, in_if.in_byte};
                        addr_d  = BASE_ADDR + (32'(words_q) << 2);
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + LEN_WIDTH'(1);
                state_d = (32'(words_q) + 32'd1 == 32'(len_q)) ? S_FINISH : S_DATA;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdy        = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
        mem_we_o   = (state_q == S_WRITE);
        cpu_hold_o = (state_q != S_IDLE) && (state_q != S_FINISH);
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_FINISH);
    end

    assign in_if.in_ready = rdy;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign err_o          = err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench: two loaders (base 0x0 and 0x100) share one byte stream;
// a table of loads plus hand sequences for mid-load reset and stray start.
module tb_inst_mem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  bdata = 8'h00;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [63:0] wq0[$];
    logic [63:0] wq1[$];

    logic        mem_we0, cpu_hold0, busy0, done0, err0;
    logic [31:0] addr0, wdata0;
    logic [15:0] wl0;
    logic        mem_we1, cpu_hold1, busy1, done1, err1;
    logic [31:0] addr1, wdata1;
    logic [15:0] wl1;

    inst_mem_loader_if if0();
    inst_mem_loader_if if1();
    assign if0.in_valid = valid;
    assign if0.in_byte  = bdata;
    assign if1.in_valid = valid;
    assign if1.in_byte  = bdata;

    inst_mem_loader #(.BASE_ADDR(32'h0), .DEPTH_WORDS(256), .LEN_WIDTH(16)) dut0 (
        .clock_i(clock), .reset_i(reset), .start_i(start), .in_if(if0),
        .mem_we_o(mem_we0), .mem_addr_o(addr0), .mem_wdata_o(wdata0),
        .cpu_hold_o(cpu_hold0), .busy_o(busy0), .done_o(done0), .err_o(err0),
        .words_loaded_o(wl0));

    inst_mem_loader #(.BASE_ADDR(32'h100), .DEPTH_WORDS(256), .LEN_WIDTH(16)) dut1 (
        .clock_i(clock), .reset_i(reset), .start_i(start), .in_if(if1),
        .mem_we_o(mem_we1), .mem_addr_o(addr1), .mem_wdata_o(wdata1),
        .cpu_hold_o(cpu_hold1), .busy_o(busy1), .done_o(done1), .err_o(err1),
        .words_loaded_o(wl1));

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] n;
        logic [63:0] data;
        int          gap;
        logic        mid_start;
        int          exp_writes;
        logic        exp_err;
        logic [15:0] exp_wl;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mem_we0) begin
            wq0.push_back({addr0, wdata0});
            chk("in_ready_during_write", {63'd0, if0.in_ready}, 64'd0);
        end
        if (mem_we1) wq1.push_back({addr1, wdata1});
        if (done0) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        int t;
        repeat (gap) begin
            @(posedge clock); #1;
        end
        valid = 1'b1;
        bdata = b;
        ok = 1'b0;
        t = 0;
        while (!ok && t < 50) begin
            @(negedge clock);
            ok = if0.in_ready;
            @(posedge clock); #1;
            t++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: byte %0h never accepted", b);
        end
        valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run_load(input vec_t v, input string tag);
        int nbytes;
        int d0;
        int t;
        wq0.delete();
        wq1.delete();
        d0 = done_cnt;
        nbytes = v.exp_err ? 0 : 4 * int'(v.n);
        pulse_start();
        @(negedge clock);
        chk({tag, "_cpu_hold_loading"}, {63'd0, cpu_hold0}, 64'd1);
        chk({tag, "_busy_loading"}, {63'd0, busy0}, 64'd1);
        @(posedge clock); #1;
        send_byte(v.n[15:8], v.gap);
        send_byte(v.n[7:0], v.gap);
        for (int i = 0; i < nbytes; i++) begin
            if (v.mid_start && i == 5) start = 1'b1;
            send_byte(v.data[63 - 8*i -: 8], v.gap);
            start = 1'b0;
        end
        if (nbytes == 0) begin
            @(negedge clock);
            chk({tag, "_done_after_len"}, {63'd0, done0}, 64'd1);
        end else begin
            t = 0;
            @(negedge clock);
            while (!done0 && t < 40) begin
                @(negedge clock);
                t++;
            end
            chk({tag, "_done_seen"}, {63'd0, done0}, 64'd1);
        end
        chk({tag, "_cpu_hold_in_finish"}, {63'd0, cpu_hold0}, 64'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_busy_after"}, {63'd0, busy0}, 64'd0);
        chk({tag, "_cpu_hold_after"}, {63'd0, cpu_hold0}, 64'd0);
        chk({tag, "_err"}, {63'd0, err0}, {63'd0, v.exp_err});
        chk({tag, "_words_loaded"}, {48'd0, wl0}, {48'd0, v.exp_wl});
        chk({tag, "_nwrites_base0"}, 64'(wq0.size()), 64'(v.exp_writes));
        chk({tag, "_nwrites_base100"}, 64'(wq1.size()), 64'(v.exp_writes));
        for (int i = 0; i < v.exp_writes && i < wq0.size() && i < wq1.size(); i++) begin
            chk({tag, "_write_base0"}, wq0[i],
                {32'(4 * i), (i == 0) ? v.exp_w0 : v.exp_w1});
            chk({tag, "_write_base100"}, wq1[i],
                {32'h100 + 32'(4 * i), (i == 0) ? v.exp_w0 : v.exp_w1});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'd2, 64'hDEADBEEF_12345678, 0, 1'b0, 2, 1'b0, 16'd2, 32'hDEADBEEF, 32'h12345678};
        vecs[1] = '{16'd2, 64'hDEADBEEF_12345678, 3, 1'b0, 2, 1'b0, 16'd2, 32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{16'd0, 64'h0, 0, 1'b0, 0, 1'b0, 16'd0, 32'h0, 32'h0};
        vecs[3] = '{16'h0101, 64'h0, 0, 1'b0, 0, 1'b1, 16'd0, 32'h0, 32'h0};
        vecs[4] = '{16'd1, 64'hCAFEBABE_00000000, 1, 1'b0, 1, 1'b0, 16'd1, 32'hCAFEBABE, 32'h0};
        vecs[5] = '{16'd2, 64'h11223344_55667788, 0, 1'b1, 2, 1'b0, 16'd2, 32'h11223344, 32'h55667788};

        // Reset with a byte offered: nothing may be accepted.
        valid = 1'b1;
        bdata = 8'hAA;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", {63'd0, if0.in_ready}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we0}, 64'd0);
        chk("rst_cpu_hold", {63'd0, cpu_hold0}, 64'd0);
        chk("rst_busy", {63'd0, busy0}, 64'd0);
        chk("rst_done", {63'd0, done0}, 64'd0);
        chk("rst_err", {63'd0, err0}, 64'd0);
        chk("rst_words_loaded", {48'd0, wl0}, 64'd0);
        chk("rst_mem_addr_base0", {32'd0, addr0}, 64'h0);
        chk("rst_mem_addr_base100", {32'd0, addr1}, 64'h100);
        chk("rst_mem_wdata", {32'd0, wdata0}, 64'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk("idle_in_ready", {63'd0, if0.in_ready}, 64'd0);
        chk("idle_busy", {63'd0, busy0}, 64'd0);
        @(posedge clock); #1;
        valid = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_load(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset after two data bytes of the first word: no write, back to idle.
        wq0.delete();
        wq1.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_busy", {63'd0, busy0}, 64'd0);
        chk("midrst_cpu_hold", {63'd0, cpu_hold0}, 64'd0);
        chk("midrst_in_ready", {63'd0, if0.in_ready}, 64'd0);
        chk("midrst_words_loaded", {48'd0, wl0}, 64'd0);
        repeat (3) @(negedge clock);
        chk("midrst_no_write", 64'(wq0.size()), 64'd0);
        @(posedge clock); #1;
        run_load(vecs[4], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
